mux16_scan_seq: RTL and testbench
=================================

# mux16_scan_seq

Scan sequencer that sits directly upstream of the 16-to-1 mux (`mux16to1_version1`). It accepts a 16-bit word on a start handshake and holds it on the mux data input. It then steps the mux select through a programmable contiguous range, one index per clock, and qualifies each selected bit with a strobe. The combination performs parallel-to-serial conversion, and downstream logic samples the mux output only when `bit_valid` is high.

## Interface
- `WIDTH`, 16, data word width; must equal 2**SEL_W
- `SEL_W`, 4, select width
- `clk` input 1: single clock, rising-edge
- `rst_n` input 1: asynchronous, active-low reset
- `start` input 1: request a scan; accepted only when `ready`=1
- `data_in` input WIDTH: word to scan, captured on accept
- `first_sel` input SEL_W: first index, captured on accept
- `last_sel` input SEL_W: last index, captured on accept
- `hold` input 1: stall; freezes the scan while high
- `abort` input 1: synchronous cancel of the scan in progress
- `mux_in` output WIDTH: registered word driving the mux `in`
- `mux_sel` output SEL_W: registered index driving the mux `sel`
- `bit_valid` output 1: mux `out` is a valid scanned bit this cycle
- `ready` output 1: idle, able to accept `start`
- `busy` output 1: scan in progress
- `done` output 1: one-cycle pulse after the last bit

## Operation
- FSM states: IDLE, SCAN, DONE.
- **IDLE**
  - `ready`=1.
  - On `start`=1: latch `data_in`→`mux_in`, `first_sel`→`mux_sel`, `last_sel`→internal `last_r`; go to SCAN.
- **SCAN**
  - `busy`=1.
  - `hold`=0: `bit_valid`=1. If `mux_sel`==`last_r`, go to DONE; otherwise increment `mux_sel` mod 2**SEL_W.
  - `hold`=1: `bit_valid`=0 and `mux_sel` is frozen.
- **DONE**
  - `done`=1 and `bit_valid`=0 for exactly one cycle, then return to IDLE.
- Wrap-around:
  - If `last_sel` < `first_sel`, the index wraps 15→0.
  - Bit count = ((last_sel − first_sel) mod 16) + 1, in the range 1..16.
  - `first_sel`==`last_sel` scans exactly one bit.
  - first=0, last=15 scans all 16 bits.
- `mux_in` is stable for the whole scan; it changes only on accept or reset.
- `start` outside IDLE is ignored; the request is not queued.
- `abort`:
  - In SCAN, `abort` has priority over `hold` and over the last-bit transition.
  - The next state is IDLE, `done` is not pulsed, and `bit_valid`=0 in the abort cycle.
  - `abort` in IDLE or DONE has no effect.
- After DONE or an abort, `mux_sel` keeps its last value.
- `ready`, `busy`, `done` and `bit_valid` are decoded from state and `hold`/`abort`; they are glitch-free relative to `clk`.

## Timing
- Reset (async assert, sync release): state=IDLE, `mux_in`=0, `mux_sel`=0, `bit_valid`=0, `busy`=0, `done`=0, `ready`=1.
- Reset mid-scan clears immediately; no `done` is produced.
- Latency from accept to first bit:
  - `start` sampled at edge k.
  - `mux_in`, `mux_sel` and SCAN become valid after edge k, so the first `bit_valid` is in cycle k+1.
- Throughput: 1 bit per cycle without `hold`.
  - N bits give `bit_valid` in cycles k+1..k+N and `done` in cycle k+N+1.
  - The earliest next accept is at edge k+N+2, when `ready` returns.
- Each cycle of `hold` adds one cycle of latency.
- Mux path: the mux is combinational, so its `out` reflects `mux_sel` in the same cycle that `bit_valid` is high.

## Structure
- Shared package `mux_scan_pkg`:
  - state encoding constants IDLE=2'd0, SCAN=2'd1, DONE=2'd2;
  - default WIDTH/SEL_W.
- One sub-module, `mux_sel_ctr`: SEL_W-bit loadable wrap counter with load, enable, and compare-equal-to-`last_r` output.
- The top level instantiates `mux_sel_ctr` and contains the FSM and the data register.
- The bench instantiates this block driving `mux16to1_version1` and checks the serial stream.

## Test plan
- **Full scan:** reset, `data_in`=16'h3f0a, first=0, last=15, `start` 1 cycle → `bit_valid` 16 cycles; mux out sequence 0,1,0,1,0,0,0,0,1,1,1,1,1,1,0,0; `done` in cycle 17.
- **Wrap range:** first=14, last=1 → `mux_sel` 14,15,0,1; exactly 4 `bit_valid`; `done` follows.
- **Single bit with stall:** first=last=6; `hold` high cycles 1–3 → `mux_sel` stays 6, `bit_valid` low while held, exactly one valid bit (0), then `done`.
- **Ignored start and abort:** `start` pulses while `busy` are ignored and `mux_in` is unchanged; `abort` at the 5th bit → IDLE next cycle, no `done`, `ready`=1.
- **Async reset mid-scan:** `rst_n` low at the 8th bit → all outputs at reset values immediately; after release a new scan with `data_in`=16'hffff outputs all ones.

Source files
------------

// File: rtl/mux16_scan_seq_pkg.sv
// -----------------------------------------------------------------------------
// mux_scan_pkg
// Shared definitions for the mux16 scan sequencer: FSM state encoding and
// default word/select widths.
// -----------------------------------------------------------------------------
package mux_scan_pkg;

   localparam int WIDTH_DEF = 16;
   localparam int SEL_W_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } scan_state_e;

endpackage : mux_scan_pkg

// File: rtl/mux16_scan_seq_if.sv
// -----------------------------------------------------------------------------
// mux16_scan_seq_if
// Handshake and mux-side signals of the scan sequencer.
//   master : requester side (drives start/data_in/first_sel/last_sel/hold/abort)
//   slave  : sequencer side (drives mux_in/mux_sel/bit_valid/ready/busy/done)
// -----------------------------------------------------------------------------
interface mux16_scan_seq_if
   import mux_scan_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int SEL_W = SEL_W_DEF
);
   logic             start;
   logic [WIDTH-1:0] data_in;
   logic [SEL_W-1:0] first_sel;
   logic [SEL_W-1:0] last_sel;
   logic             hold;
   logic             abort;
   logic [WIDTH-1:0] mux_in;
   logic [SEL_W-1:0] mux_sel;
   logic             bit_valid;
   logic             ready;
   logic             busy;
   logic             done;

   modport master (
      output start, data_in, first_sel, last_sel, hold, abort,
      input  mux_in, mux_sel, bit_valid, ready, busy, done
   );

   modport slave (
      input  start, data_in, first_sel, last_sel, hold, abort,
      output mux_in, mux_sel, bit_valid, ready, busy, done
   );
endinterface : mux16_scan_seq_if

// File: rtl/mux16_scan_seq_sel_ctr.sv
// -----------------------------------------------------------------------------
// mux_sel_ctr
// Loadable SEL_W-bit index counter that wraps modulo 2**SEL_W.
//   clk, rst_n  : clock, async active-low reset (count clears to 0)
//   load_i      : load load_val_i (priority over en_i)
//   load_val_i  : value to load
//   en_i        : increment by one
//   last_i      : compare value
//   cnt_o       : current index
//   eq_o        : cnt_o == last_i
// -----------------------------------------------------------------------------
module mux_sel_ctr #(
   parameter int SEL_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [SEL_W-1:0] load_val_i,
   input  logic             en_i,
   input  logic [SEL_W-1:0] last_i,
   output logic [SEL_W-1:0] cnt_o,
   output logic             eq_o
);
   logic [SEL_W-1:0] cnt_q;
   logic [SEL_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i) begin
         cnt_d = cnt_q + SEL_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;
   assign eq_o  = (cnt_q == last_i);
endmodule : mux_sel_ctr

// File: rtl/mux16to1_version1.sv
// -----------------------------------------------------------------------------
// mux16to1_version1
// Combinational 16-to-1 bit multiplexer fed by the scan sequencer.
//   in  : 16-bit data word
//   sel : bit index
//   out : in[sel]
// -----------------------------------------------------------------------------
module mux16to1_version1 (
   input  logic [15:0] in,
   input  logic [3:0]  sel,
   output logic        out
);
   assign out = in[sel];
endmodule : mux16to1_version1

// File: rtl/mux16_scan_seq.sv
// -----------------------------------------------------------------------------
// mux16_scan_seq
// Parallel-to-serial scan sequencer for a 16-to-1 mux. A word is captured on
// an accepted start and held on mux_in; mux_sel then walks first_sel..last_sel
// (wrapping), one index per clock, with bit_valid qualifying each bit.
//   clk, rst_n : clock, async active-low reset
//   bus        : mux16_scan_seq_if.slave (handshake in, mux drive/status out)
//
//   state | meaning
//   IDLE  | ready, waiting for start
//   SCAN  | stepping mux_sel, bit_valid unless held or aborted
//   DONE  | one-cycle done pulse, then IDLE
// -----------------------------------------------------------------------------
module mux16_scan_seq
   import mux_scan_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int SEL_W = SEL_W_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   mux16_scan_seq_if.slave bus
);
   scan_state_e      state_q, state_d;
   logic [WIDTH-1:0] mux_in_q;
   logic [SEL_W-1:0] last_q;
   logic             load;
   logic             step;
   logic             at_last;
   logic [SEL_W-1:0] sel_cnt;

   mux_sel_ctr #(.SEL_W(SEL_W)) u_sel_ctr (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (load),
      .load_val_i (bus.first_sel),
      .en_i       (step),
      .last_i     (last_q),
      .cnt_o      (sel_cnt),
      .eq_o       (at_last)
   );

   // abort outranks hold and the last-bit exit; the counter only advances
   // on a non-final, unheld, unaborted SCAN cycle so mux_sel stays on the
   // last index after DONE or an abort.
   always_comb begin
      state_d       = state_q;
      load          = 1'b0;
      step          = 1'b0;
      bus.ready     = 1'b0;
      bus.busy      = 1'b0;
      bus.done      = 1'b0;
      bus.bit_valid = 1'b0;
      case (state_q)
         IDLE: begin
            bus.ready = 1'b1;
            if (bus.start) begin
               load    = 1'b1;
               state_d = SCAN;
            end
         end
         SCAN: begin
            bus.busy = 1'b1;
            if (bus.abort) begin
               state_d = IDLE;
            end else if (!bus.hold) begin
               bus.bit_valid = 1'b1;
               if (at_last) begin
                  state_d = DONE;
               end else begin
                  step = 1'b1;
               end
            end
         end
         DONE: begin
            bus.done = 1'b1;
            state_d  = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         mux_in_q <= '0;
         last_q   <= '0;
      end else begin
         state_q <= state_d;
         if (load) begin
            mux_in_q <= bus.data_in;
            last_q   <= bus.last_sel;
         end
      end
   end

   assign bus.mux_in  = mux_in_q;
   assign bus.mux_sel = sel_cnt;
endmodule : mux16_scan_seq

// File: tb/tb_mux16_scan_seq.sv
// -----------------------------------------------------------------------------
// tb_mux16_scan_seq
// Directed bench: scan sequencer driving mux16to1_version1, checking the
// serial stream, handshake timing, hold, abort, ignored start and reset.
// -----------------------------------------------------------------------------
module tb_mux16_scan_seq;
   logic clk = 1'b0;
   logic rst_n;
   logic ser_out;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   mux16_scan_seq_if #(.WIDTH(16), .SEL_W(4)) bus ();

   mux16_scan_seq #(.WIDTH(16), .SEL_W(4)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   mux16to1_version1 u_mux (
      .in  (bus.mux_in),
      .sel (bus.mux_sel),
      .out (ser_out)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // inputs change 1 time unit after the rising edge, checks 4 units after it
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_mux_in"}, 32'(bus.mux_in), 32'h0);
      chk({tag, "_mux_sel"}, 32'(bus.mux_sel), 32'h0);
      chk({tag, "_bit_valid"}, 32'(bus.bit_valid), 32'h0);
      chk({tag, "_busy"}, 32'(bus.busy), 32'h0);
      chk({tag, "_done"}, 32'(bus.done), 32'h0);
      chk({tag, "_ready"}, 32'(bus.ready), 32'h1);
   endtask

   // Full scan of first..last with no hold; expected index and bit derived
   // from the applied word and range.
   task automatic run_scan(input string tag, input logic [15:0] d,
                           input logic [3:0] f, input logic [3:0] l);
      int         n;
      logic [3:0] s;
      logic [3:0] span;
      span = l - f;
      n    = int'(span) + 1;
      bus.data_in   = d;
      bus.first_sel = f;
      bus.last_sel  = l;
      bus.start     = 1'b1;
      #3;
      chk({tag, "_ready_pre"}, 32'(bus.ready), 32'h1);
      cyc();
      bus.start   = 1'b0;
      bus.data_in = ~d;
      for (int i = 0; i < n; i++) begin
         s = f + 4'(i);
         #3;
         chk({tag, "_bv"}, 32'(bus.bit_valid), 32'h1);
         chk({tag, "_sel"}, 32'(bus.mux_sel), 32'(s));
         chk({tag, "_bit"}, 32'(ser_out), 32'(d[s]));
         chk({tag, "_mux_in"}, 32'(bus.mux_in), 32'(d));
         cyc();
      end
      #3;
      chk({tag, "_done"}, 32'(bus.done), 32'h1);
      chk({tag, "_done_bv"}, 32'(bus.bit_valid), 32'h0);
      chk({tag, "_done_sel"}, 32'(bus.mux_sel), 32'(l));
      cyc();
      #3;
      chk({tag, "_ready_post"}, 32'(bus.ready), 32'h1);
      chk({tag, "_done_clr"}, 32'(bus.done), 32'h0);
      cyc();
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.start     = 1'b0;
      bus.data_in   = '0;
      bus.first_sel = '0;
      bus.last_sel  = '0;
      bus.hold      = 1'b0;
      bus.abort     = 1'b0;
      #12;
      chk_reset_vals("rst");
      rst_n = 1'b1;
      cyc();

      // full scan, stream 0,1,0,1,0,0,0,0,1,1,1,1,1,1,0,0
      run_scan("full", 16'h3f0a, 4'd0, 4'd15);

      // wrap range 14,15,0,1
      run_scan("wrap", 16'h8001, 4'd14, 4'd1);

      // abort while idle is a no-op
      bus.abort = 1'b1;
      #3;
      chk("idle_abort_ready", 32'(bus.ready), 32'h1);
      cyc();
      bus.abort = 1'b0;
      #3;
      chk("idle_abort_ready2", 32'(bus.ready), 32'h1);
      chk("idle_abort_busy", 32'(bus.busy), 32'h0);
      cyc();

      // single bit at index 6 (value 0) with three held cycles
      bus.data_in   = 16'h00bf;
      bus.first_sel = 4'd6;
      bus.last_sel  = 4'd6;
      bus.start     = 1'b1;
      cyc();
      bus.start = 1'b0;
      bus.hold  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #3;
         chk("hold_bv", 32'(bus.bit_valid), 32'h0);
         chk("hold_sel", 32'(bus.mux_sel), 32'd6);
         chk("hold_busy", 32'(bus.busy), 32'h1);
         cyc();
      end
      bus.hold = 1'b0;
      #3;
      chk("single_bv", 32'(bus.bit_valid), 32'h1);
      chk("single_bit", 32'(ser_out), 32'h0);
      cyc();
      #3;
      chk("single_done", 32'(bus.done), 32'h1);
      chk("single_done_bv", 32'(bus.bit_valid), 32'h0);
      cyc();
      #3;
      chk("single_ready", 32'(bus.ready), 32'h1);
      cyc();

      // ignored start while busy, then abort at the 5th bit (index 6)
      bus.data_in   = 16'ha5c3;
      bus.first_sel = 4'd2;
      bus.last_sel  = 4'd12;
      bus.start     = 1'b1;
      cyc();
      bus.start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i == 1 || i == 2) begin
            bus.start     = 1'b1;
            bus.data_in   = 16'h1234;
            bus.first_sel = 4'd0;
         end else begin
            bus.start = 1'b0;
         end
         #3;
         chk("ign_sel", 32'(bus.mux_sel), 32'(4'd2 + 4'(i)));
         chk("ign_mux_in", 32'(bus.mux_in), 32'ha5c3);
         chk("ign_ready", 32'(bus.ready), 32'h0);
         cyc();
      end
      bus.start = 1'b0;
      bus.abort = 1'b1;
      bus.hold  = 1'b1;
      #3;
      chk("abort_bv", 32'(bus.bit_valid), 32'h0);
      chk("abort_sel", 32'(bus.mux_sel), 32'd6);
      cyc();
      bus.abort = 1'b0;
      bus.hold  = 1'b0;
      #3;
      chk("abort_ready", 32'(bus.ready), 32'h1);
      chk("abort_done", 32'(bus.done), 32'h0);
      chk("abort_sel_kept", 32'(bus.mux_sel), 32'd6);
      chk("abort_mux_in", 32'(bus.mux_in), 32'ha5c3);
      cyc();
      #3;
      chk("abort_done2", 32'(bus.done), 32'h0);
      cyc();

      // async reset at the 8th bit of a full scan
      bus.data_in   = 16'h5a5a;
      bus.first_sel = 4'd0;
      bus.last_sel  = 4'd15;
      bus.start     = 1'b1;
      cyc();
      bus.start = 1'b0;
      for (int i = 0; i < 7; i++) cyc();
      #3;
      chk("rstmid_bv", 32'(bus.bit_valid), 32'h1);
      chk("rstmid_sel", 32'(bus.mux_sel), 32'd7);
      rst_n = 1'b0;
      #1;
      chk_reset_vals("rstmid");
      cyc();
      #3;
      chk("rstmid_done", 32'(bus.done), 32'h0);
      rst_n = 1'b1;
      cyc();
      #3;
      chk_reset_vals("rstrel");
      cyc();

      run_scan("ones", 16'hffff, 4'd0, 4'd15);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running want finished");
      $fatal(1);
   end
endmodule : tb_mux16_scan_seq
